reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised integer register file with write-to-read bypass, hardwired-zero register 0 and a per-register busy scoreboard. It sits between decode and writeback in the RISC-V core. Decode reads operands and reserves destination registers. Writeback writes results and releases those reservations. Decode uses the busy flags to stall on RAW hazards and to refuse WAW issues.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (2..64)
- AW, $clog2(NREG), register address width
- NRP, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads see array contents only

- clk  in  1  the only clock; everything samples on its rising edge
- reset  in  1  synchronous, active-low reset
- rd_addr  in  NRP*AW  read addresses; port k occupies bits [k*AW +: AW]
- rd_data  out  NRP*XLEN  read data, one slice per port
- rd_busy  out  NRP  per port: the addressed register still has a pending write
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback value
- iss_en  in  1  request to reserve a destination register
- iss_addr  in  AW  destination register to reserve
- iss_ready  out  1  the reservation is accepted this cycle
- flush  in  1  clears all reservations (pipeline squash)
- pend_cnt  out  AW+1  number of registers currently reserved

## Operation
- Storage:
  - Data array regs[1..NREG-1] of XLEN bits.
  - busy[NREG-1:1] flags.
  - pend_cnt counter.
  - Register 0 has no storage: it always reads 0, is never busy, and writes to it are dropped.
- Out of range: any address >= NREG (possible when NREG is not a power of 2)
  - reads 0 and reports not busy;
  - writes to it are dropped;
  - issues to it give iss_ready=0.
- Read port k:
  - A "hit" is BYPASS=1, wr_en=1, wr_addr==rd_addr[k] and wr_addr!=0.
  - rd_data[k] = wr_data on a hit, otherwise regs[rd_addr[k]].
  - rd_busy[k] = busy[a] && !(wr_en && wr_addr==a), where a = rd_addr[k].
  - The rd_busy release is independent of BYPASS. With BYPASS=0 decode must still wait one cycle on a release.
- Write: when wr_en=1 and wr_addr is in range and nonzero, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Issue:
  - iss_ready = iss_en && !flush && (iss_addr==0 || (addr in range && (!busy[iss_addr] || (wr_en && wr_addr==iss_addr)))).
  - On acceptance with a nonzero address, busy[iss_addr] <= 1.
  - Issue to register 0 is accepted with no state change.
- Same register, same cycle: an accepted issue and a write to that register leave busy=1. The set wins and data updates.
- Flush:
  - All busy bits <= 0 and pend_cnt <= 0.
  - Any issue in the same cycle is refused.
  - A write in the same cycle still updates the data array.
- pend_cnt:
  - Next value = pend_cnt + (accepted nonzero issue) − (write clearing a set busy bit).
  - It always equals the popcount of busy.
  - A write to a non-busy register does not decrement it.

## Timing
- Reads are combinational from rd_addr and the write inputs: zero latency.
- Writes, reservations and flush take effect at the next rising edge. A reservation is visible on rd_busy in the following cycle.
- Reset (reset=0 at the edge):
  - all regs, busy and pend_cnt go to 0;
  - rd_data reads 0, rd_busy=0, pend_cnt=0;
  - reset overrides wr_en, iss_en and flush;
  - iss_ready is still evaluated combinationally during reset, but nothing is committed.
- Reset asserted mid-operation discards all outstanding reservations. Writebacks that arrive afterwards for those registers only update data.

## Structure
- Shared core package:
  - REG_ZERO address constant;
  - default XLEN/NREG;
  - function clog2 if the toolchain lacks $clog2.
- One sub-module, reg_file_sb_rport: a single read port containing the bypass mux, the busy mask and the zero/range check. It is instantiated NRP times in a generate loop.
- The scoreboard and the counter live in the top module.

## Test plan
- Reset then read all ports at addresses 0..NREG-1 -> all rd_data=0, rd_busy=0, pend_cnt=0.
- Issue x5, next cycle read x5 -> rd_busy=1 and pend_cnt=1. Write x5=0xDEADBEEF while reading x5 -> same cycle rd_data=0xDEADBEEF (BYPASS=1), rd_busy=0. Next cycle pend_cnt=0.
- Issue x7, then issue x7 again -> second iss_ready=0. Issue x7 in the same cycle as a write to x7 -> iss_ready=1, busy stays 1, pend_cnt unchanged.
- Write x0=0x1234 with iss_en on x0 -> reads of x0 return 0, iss_ready=1, pend_cnt unchanged.
- Reserve x1, x2, x3 (pend_cnt=3), then flush with iss_en on x4 -> iss_ready=0. Next cycle pend_cnt=0 and all busy=0.
- NREG=24: write to address 30 -> dropped, reads of it return 0, issue to it gives iss_ready=0. Also drive reset low mid-stream -> all state is 0 at the next edge.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// ============================================================================
// Module      : reg_file_sb_pkg
// Description : Shared constants and helpers for the scoreboarded register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_sb_pkg;

    localparam int unsigned DEF_XLEN = 32;
    localparam int unsigned DEF_NREG = 32;
    localparam int unsigned REG_ZERO = 0;

    // Ceiling log2, usable in parameter defaults on toolchains without $clog2.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_sb_rport.sv
// ============================================================================
// Module      : reg_file_sb_rport
// Description : One read port: range/zero check, write bypass and busy masking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_sb_rport
    import reg_file_sb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]   rd_addr_i,
    input  logic [XLEN-1:0] regs_i [NREG],
    input  logic [NREG-1:0] busy_i,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_busy_o
);

    localparam logic [AW:0] NREG_LIM = (AW+1)'(NREG);

    logic w_valid;
    logic w_wr_match;
    logic w_hit;

    assign w_valid    = ({1'b0, rd_addr_i} < NREG_LIM) && (rd_addr_i != AW'(REG_ZERO));
    assign w_wr_match = wr_en_i && (wr_addr_i == rd_addr_i);
    assign w_hit      = (BYPASS != 0) && w_wr_match;

    // The busy release follows the write strobe even without data forwarding.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = 1'b0;
        if (w_valid) begin
            rd_data_o = w_hit ? wr_data_i : regs_i[rd_addr_i];
            rd_busy_o = busy_i[rd_addr_i] && !w_wr_match;
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
// ============================================================================
// Module      : reg_file_sb
// Description : Integer register file with bypass, hardwired x0 and busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREG   = DEF_NREG,
    parameter int AW     = clog2(NREG),
    parameter int NRP    = 2,
    parameter int BYPASS = 1
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic [NRP*AW-1:0]   rd_addr_i,
    output logic [NRP*XLEN-1:0] rd_data_o,
    output logic [NRP-1:0]      rd_busy_o,
    input  logic                wr_en_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [XLEN-1:0]     wr_data_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    output logic                iss_ready_o,
    input  logic                flush_i,
    output logic [AW:0]         pend_cnt_o
);

    localparam logic [AW:0] NREG_LIM = (AW+1)'(NREG);

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] w_regs [NREG];
    logic [NREG-1:1] busy_q;
    logic [NREG-1:1] busy_d;
    logic [NREG-1:0] w_busy;
    logic [AW:0]     pend_q;
    logic [AW:0]     pend_d;

    logic w_wr_ok;
    logic w_wr_clr;
    logic w_iss_zero;
    logic w_iss_in_range;
    logic w_iss_blocked;
    logic w_iss_set;

    always_comb begin
        w_regs[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            w_regs[i] = regs_q[i];
        end
    end

    assign w_busy = {busy_q, 1'b0};

    assign w_wr_ok        = wr_en_i && (wr_addr_i != AW'(REG_ZERO)) && ({1'b0, wr_addr_i} < NREG_LIM);
    assign w_wr_clr       = w_wr_ok && w_busy[wr_addr_i];
    assign w_iss_zero     = (iss_addr_i == AW'(REG_ZERO));
    assign w_iss_in_range = ({1'b0, iss_addr_i} < NREG_LIM);
    assign w_iss_blocked  = w_busy[iss_addr_i] && !(wr_en_i && (wr_addr_i == iss_addr_i));
    assign iss_ready_o    = iss_en_i && !flush_i &&
                            (w_iss_zero || (w_iss_in_range && !w_iss_blocked));
    assign w_iss_set      = iss_ready_o && !w_iss_zero;

    // Set is applied after clear so a same-cycle issue and write leave the bit set.
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (w_wr_ok) begin
                busy_d[wr_addr_i] = 1'b0;
            end
            if (w_iss_set) begin
                busy_d[iss_addr_i] = 1'b1;
            end
        end
    end

    assign pend_d = flush_i ? '0 : (pend_q + (AW+1)'(w_iss_set) - (AW+1)'(w_wr_clr));

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            if (w_wr_ok) begin
                regs_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    assign pend_cnt_o = pend_q;

    for (genvar k = 0; k < NRP; k++) begin : g_rport
        reg_file_sb_rport #(
            .XLEN   (XLEN),
            .NREG   (NREG),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_rport (
            .rd_addr_i (rd_addr_i[k*AW +: AW]),
            .regs_i    (w_regs),
            .busy_i    (w_busy),
            .wr_en_i   (wr_en_i),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .rd_data_o (rd_data_o[k*XLEN +: XLEN]),
            .rd_busy_o (rd_busy_o[k])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// ============================================================================
// Module      : tb_reg_file_sb
// Description : Directed scoreboard bench for reg_file_sb (NREG=24, two read ports).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_sb;

    localparam int XLEN = 32;
    localparam int NREG = 24;
    localparam int AW   = 5;
    localparam int NRP  = 2;

    localparam int K_D0  = 0;
    localparam int K_D1  = 1;
    localparam int K_B0  = 2;
    localparam int K_B1  = 3;
    localparam int K_RDY = 4;
    localparam int K_CNT = 5;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    logic                clk;
    logic                reset_n;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                iss_ready;
    logic                flush;
    logic [AW:0]         pend_cnt;

    exp_t sb_q[$];
    int   checks;
    int   failures;

    reg_file_sb #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .AW     (AW),
        .NRP    (NRP),
        .BYPASS (1)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_busy_o   (rd_busy),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .iss_en_i    (iss_en),
        .iss_addr_i  (iss_addr),
        .iss_ready_o (iss_ready),
        .flush_i     (flush),
        .pend_cnt_o  (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_D0:    return rd_data[31:0];
            K_D1:    return rd_data[63:32];
            K_B0:    return {31'd0, rd_busy[0]};
            K_B1:    return {31'd0, rd_busy[1]};
            K_RDY:   return {31'd0, iss_ready};
            default: return {26'd0, pend_cnt};
        endcase
    endfunction

    task automatic drive(input logic rst_n, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                         input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [AW-1:0] ia, input logic fl);
        reset_n  = rst_n;
        rd_addr  = {ra1, ra0};
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = ia;
        flush    = fl;
    endtask

    task automatic expect_val(input int kind, input logic [31:0] v, input string tag);
        sb_q.push_back('{kind, v, tag});
    endtask

    // Let combinational outputs settle, retire every queued expectation, then advance a cycle.
    task automatic tick();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.kind);
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 1'b0);
        @(negedge clk);
        tick();
        // Second reset cycle: state already cleared, iss_ready still evaluated.
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 1'b0);
        expect_val(K_RDY, 32'd1, "rst_iss_ready");
        tick();

        for (int a = 0; a < NREG; a++) begin
            drive(1'b1, 5'(a), 5'(NREG-1-a), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
            expect_val(K_D0, 32'd0, "rst_d0");
            expect_val(K_D1, 32'd0, "rst_d1");
            expect_val(K_B0, 32'd0, "rst_b0");
            expect_val(K_B1, 32'd0, "rst_b1");
            expect_val(K_CNT, 32'd0, "rst_cnt");
            tick();
        end

        // Reserve x5, then write it back with same-cycle bypass.
        drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0);
        expect_val(K_RDY, 32'd1, "iss5_ready");
        expect_val(K_B0, 32'd0, "iss5_b0_same_cycle");
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        expect_val(K_B0, 32'd1, "x5_busy");
        expect_val(K_CNT, 32'd1, "x5_cnt1");
        tick();
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        expect_val(K_D0, 32'hDEADBEEF, "x5_bypass_d0");
        expect_val(K_D1, 32'hDEADBEEF, "x5_bypass_d1");
        expect_val(K_B0, 32'd0, "x5_release_b0");
        expect_val(K_CNT, 32'd1, "x5_cnt_before_wb");
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        expect_val(K_D0, 32'hDEADBEEF, "x5_stored");
        expect_val(K_B0, 32'd0, "x5_not_busy");
        expect_val(K_CNT, 32'd0, "x5_cnt0");
        tick();

        // WAW refusal on x7, then issue coinciding with a write to x7.
        drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0);
        expect_val(K_RDY, 32'd1, "iss7_first");
        tick();
        drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0);
        expect_val(K_RDY, 32'd0, "iss7_waw_refused");
        expect_val(K_B0, 32'd1, "x7_busy");
        expect_val(K_CNT, 32'd1, "x7_cnt1");
        tick();
        drive(1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 1'b0);
        expect_val(K_RDY, 32'd1, "iss7_with_wb");
        expect_val(K_D0, 32'h77, "x7_bypass");
        expect_val(K_B0, 32'd0, "x7_release_mask");
        tick();
        drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        expect_val(K_B0, 32'd1, "x7_still_busy");
        expect_val(K_CNT, 32'd1, "x7_cnt_unchanged");
        expect_val(K_D0, 32'h77, "x7_data");
        tick();

        // x0: write dropped, issue accepted without reservation.
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 1'b0);
        expect_val(K_D0, 32'd0, "x0_no_bypass_d0");
        expect_val(K_D1, 32'd0, "x0_no_bypass_d1");
        expect_val(K_RDY, 32'd1, "x0_iss_ready");
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        expect_val(K_D0, 32'd0, "x0_reads_zero");
        expect_val(K_B0, 32'd0, "x0_not_busy");
        expect_val(K_CNT, 32'd1, "x0_cnt_unchanged");
        tick();

        // Release x7, reserve x1..x3, then flush alongside an issue and a write.
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd7, 32'h70, 1'b0, 5'd0, 1'b0);
        tick();
        for (int r = 1; r <= 3; r++) begin
            drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 1'b0);
            expect_val(K_RDY, 32'd1, "iss_123_ready");
            expect_val(K_CNT, 32'(r-1), "iss_123_cnt");
            tick();
        end
        drive(1'b1, 5'd1, 5'd3, 1'b1, 5'd2, 32'hABCD, 1'b1, 5'd4, 1'b1);
        expect_val(K_RDY, 32'd0, "flush_iss_refused");
        expect_val(K_CNT, 32'd3, "pre_flush_cnt3");
        expect_val(K_B0, 32'd1, "pre_flush_b1");
        expect_val(K_B1, 32'd1, "pre_flush_b3");
        tick();
        drive(1'b1, 5'd2, 5'd1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0);
        expect_val(K_CNT, 32'd0, "post_flush_cnt0");
        expect_val(K_D0, 32'hABCD, "flush_wb_data");
        expect_val(K_B0, 32'd0, "post_flush_b2");
        expect_val(K_B1, 32'd0, "post_flush_b1");
        expect_val(K_RDY, 32'd1, "post_flush_iss2");
        tick();

        // Out-of-range address 30 and 24 with NREG=24.
        drive(1'b1, 5'd30, 5'd24, 1'b1, 5'd30, 32'hBAD, 1'b1, 5'd30, 1'b0);
        expect_val(K_RDY, 32'd0, "oor30_iss_refused");
        expect_val(K_D0, 32'd0, "oor30_no_bypass");
        expect_val(K_B0, 32'd0, "oor30_not_busy");
        expect_val(K_CNT, 32'd1, "oor_cnt1");
        tick();
        drive(1'b1, 5'd30, 5'd24, 1'b0, 5'd0, 32'd0, 1'b1, 5'd24, 1'b0);
        expect_val(K_D0, 32'd0, "oor30_read_zero");
        expect_val(K_D1, 32'd0, "oor24_read_zero");
        expect_val(K_RDY, 32'd0, "oor24_iss_refused");
        expect_val(K_CNT, 32'd1, "oor_cnt_unchanged");
        tick();

        // Mid-stream reset discards reservations; later writeback only updates data.
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd10, 32'h1010, 1'b1, 5'd9, 1'b0);
        expect_val(K_RDY, 32'd1, "iss9_ready");
        tick();
        drive(1'b0, 5'd9, 5'd10, 1'b1, 5'd12, 32'h1212, 1'b1, 5'd11, 1'b0);
        expect_val(K_CNT, 32'd2, "pre_reset_cnt2");
        expect_val(K_B0, 32'd1, "pre_reset_b9");
        expect_val(K_RDY, 32'd1, "reset_iss_comb");
        tick();
        drive(1'b1, 5'd10, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        expect_val(K_D0, 32'd0, "post_reset_x10");
        expect_val(K_B1, 32'd0, "post_reset_b9");
        expect_val(K_CNT, 32'd0, "post_reset_cnt0");
        tick();
        drive(1'b1, 5'd12, 5'd11, 1'b1, 5'd9, 32'h99, 1'b1, 5'd12, 1'b0);
        expect_val(K_D0, 32'd0, "post_reset_x12");
        expect_val(K_B1, 32'd0, "post_reset_b11");
        expect_val(K_RDY, 32'd1, "post_reset_iss12");
        tick();
        drive(1'b1, 5'd9, 5'd12, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        expect_val(K_D0, 32'h99, "late_wb_data");
        expect_val(K_B1, 32'd1, "x12_busy");
        expect_val(K_CNT, 32'd1, "late_wb_no_decrement");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
